// File: rtl/ram_port_arbiter_pkg.sv
// Shared RAM geometry and client identifiers for the dual-client read arbiter.
//   RAM_ADDR_W / RAM_DATA_W / RAM_STRB_W : default RAM word-address, word and
//                                          byte-enable widths
//   client_id_e                          : read client identifier
//   rd_tag_t                             : valid + client tag carried alongside
//                                          an in-flight RAM read
package ram_port_arbiter_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 64;
  localparam int RAM_STRB_W = RAM_DATA_W / 8;

  typedef enum logic {
    CLI0 = 1'b0,
    CLI1 = 1'b1
  } client_id_e;

  typedef struct packed {
    logic       valid;
    client_id_e id;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_rr.sv
// rr_arb2: two-way round-robin selector with a grant-qualified pointer.
// Ports:
//   clock, reset_n  : clock and synchronous active-low reset
//   req0, req1      : read request valids from client 0 / client 1
//   stall           : suppress the grant this cycle (pointer holds)
//   sel_valid       : at least one request present
//   sel_id          : client chosen this cycle (independent of stall)
//   gnt0, gnt1      : one-hot grant, never asserted during reset
// sel_id never depends on stall, so the caller may derive stall from the
// chosen client's address without forming a combinational loop.
module rr_arb2
  import ram_port_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       stall,
  output logic       sel_valid,
  output client_id_e sel_id,
  output logic       gnt0,
  output logic       gnt1
);

  // Client preferred when both request; it is the one not granted last.
  client_id_e prefer;
  logic       grant_ok;

  always_comb begin
    sel_valid = req0 | req1;
    sel_id    = CLI0;
    if (req0 && req1) begin
      sel_id = prefer;
    end else if (req1) begin
      sel_id = CLI1;
    end
    grant_ok = reset_n && sel_valid && !stall;
    gnt0     = grant_ok && (sel_id == CLI0);
    gnt1     = grant_ok && (sel_id == CLI1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prefer <= CLI0;
    end else if (grant_ok) begin
      prefer <= (sel_id == CLI0) ? CLI1 : CLI0;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM read port between two read clients and
// passes a single writer straight through to the RAM write port.
// Ports:
//   clock, reset_n                    : sole clock, synchronous active-low reset
//   io_rd{0,1}_valid/ready/addr       : client read requests
//   io_rd{0,1}_resp_valid/resp_data   : client read responses (no backpressure)
//   io_wr_valid/addr/data/strb        : writer, always accepted
//   io_ram_ena/wea/addra/dina         : RAM write port
//   io_ram_enb/addrb, io_ram_doutb    : RAM read port, 2-cycle read latency
//   io_busy                           : a read is in flight
//   io_stat_rd_cnt/stall_cnt          : wrapping grant / hazard-stall counts
// Handshake: a read request transfers in the cycle where its valid and ready
// are both high; ready is only ever driven high while valid is high, and the
// response pulses resp_valid for exactly one cycle two cycles later.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              io_rd0_valid,
  output logic              io_rd0_ready,
  input  logic [ADDR_W-1:0] io_rd0_addr,
  output logic              io_rd0_resp_valid,
  output logic [DATA_W-1:0] io_rd0_resp_data,
  input  logic              io_rd1_valid,
  output logic              io_rd1_ready,
  input  logic [ADDR_W-1:0] io_rd1_addr,
  output logic              io_rd1_resp_valid,
  output logic [DATA_W-1:0] io_rd1_resp_data,
  input  logic              io_wr_valid,
  input  logic [ADDR_W-1:0] io_wr_addr,
  input  logic [DATA_W-1:0] io_wr_data,
  input  logic [STRB_W-1:0] io_wr_strb,
  output logic              io_ram_ena,
  output logic [STRB_W-1:0] io_ram_wea,
  output logic [ADDR_W-1:0] io_ram_addra,
  output logic [DATA_W-1:0] io_ram_dina,
  output logic              io_ram_enb,
  output logic [ADDR_W-1:0] io_ram_addrb,
  input  logic [DATA_W-1:0] io_ram_doutb,
  output logic              io_busy,
  output logic [15:0]       io_stat_rd_cnt,
  output logic [15:0]       io_stat_stall_cnt
);

  logic              sel_valid;
  client_id_e        sel_id;
  logic              gnt0;
  logic              gnt1;
  logic              grant;
  logic              hazard;
  logic [ADDR_W-1:0] sel_addr;
  rd_tag_t           s1;
  rd_tag_t           s2;

  assign sel_addr = (sel_id == CLI1) ? io_rd1_addr : io_rd0_addr;

  // A read issued in the same cycle as a real write to the same word would
  // return pre-write data; hold the read one cycle so it sees the new word.
  // A write with no byte enables changes nothing and is not a hazard.
  assign hazard = sel_valid && io_wr_valid && (io_wr_strb != '0) &&
                  (io_wr_addr == sel_addr);

  rr_arb2 u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req0      (io_rd0_valid),
    .req1      (io_rd1_valid),
    .stall     (hazard),
    .sel_valid (sel_valid),
    .sel_id    (sel_id),
    .gnt0      (gnt0),
    .gnt1      (gnt1)
  );

  assign grant        = gnt0 | gnt1;
  assign io_rd0_ready = gnt0;
  assign io_rd1_ready = gnt1;
  assign io_ram_enb   = grant;
  assign io_ram_addrb = sel_addr;

  assign io_ram_ena   = io_wr_valid & reset_n;
  assign io_ram_wea   = io_wr_strb;
  assign io_ram_addra = io_wr_addr;
  assign io_ram_dina  = io_wr_data;

  // Stage registers still hold pre-reset contents during the first reset
  // cycle, so the visible outputs are also qualified by reset_n.
  assign io_rd0_resp_valid = reset_n && s2.valid && (s2.id == CLI0);
  assign io_rd1_resp_valid = reset_n && s2.valid && (s2.id == CLI1);
  assign io_rd0_resp_data  = io_ram_doutb;
  assign io_rd1_resp_data  = io_ram_doutb;
  assign io_busy           = reset_n && (s1.valid || s2.valid);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1                <= '0;
      s2                <= '0;
      io_stat_rd_cnt    <= '0;
      io_stat_stall_cnt <= '0;
    end else begin
      s1.valid <= grant;
      s1.id    <= sel_id;
      s2       <= s1;
      if (grant) begin
        io_stat_rd_cnt <= io_stat_rd_cnt + 16'd1;
      end
      if (hazard) begin
        io_stat_stall_cnt <= io_stat_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a table of per-cycle vectors with hand-computed
// grants and counter values, a RAM model behind the read/write ports, a
// response scoreboard, and hand-written reset and counter-wrap sequences.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int W  = 16 + 1 + DW;  // {due cycle, client id, data}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset_n;
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          rd0_valid, rd0_ready, rd0_resp_valid;
  logic [AW-1:0] rd0_addr;
  logic [DW-1:0] rd0_resp_data;
  logic          rd1_valid, rd1_ready, rd1_resp_valid;
  logic [AW-1:0] rd1_addr;
  logic [DW-1:0] rd1_resp_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          ram_ena, ram_enb, busy;
  logic [SW-1:0] ram_wea;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;
  logic [15:0]   rd_cnt, stall_cnt;

  ram_port_arbiter dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .io_rd0_valid      (rd0_valid),
    .io_rd0_ready      (rd0_ready),
    .io_rd0_addr       (rd0_addr),
    .io_rd0_resp_valid (rd0_resp_valid),
    .io_rd0_resp_data  (rd0_resp_data),
    .io_rd1_valid      (rd1_valid),
    .io_rd1_ready      (rd1_ready),
    .io_rd1_addr       (rd1_addr),
    .io_rd1_resp_valid (rd1_resp_valid),
    .io_rd1_resp_data  (rd1_resp_data),
    .io_wr_valid       (wr_valid),
    .io_wr_addr        (wr_addr),
    .io_wr_data        (wr_data),
    .io_wr_strb        (wr_strb),
    .io_ram_ena        (ram_ena),
    .io_ram_wea        (ram_wea),
    .io_ram_addra      (ram_addra),
    .io_ram_dina       (ram_dina),
    .io_ram_enb        (ram_enb),
    .io_ram_addrb      (ram_addrb),
    .io_ram_doutb      (ram_doutb),
    .io_busy           (busy),
    .io_stat_rd_cnt    (rd_cnt),
    .io_stat_stall_cnt (stall_cnt)
  );

  // ---------------- RAM model (byte writes, 2-cycle read) ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_p1;

  function automatic logic [DW-1:0] init_word(int i);
    if (i == 5)  return 64'hA5;
    if (i == 16) return 64'hDEAD_BEEF;
    return 64'h1000_0000_0000_0000 + 64'(i);
  endfunction

  function automatic logic [DW-1:0] byte_mask(logic [SW-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
    end else if (ram_ena) begin
      mem[ram_addra] <= (mem[ram_addra] & ~byte_mask(ram_wea)) |
                        (ram_dina & byte_mask(ram_wea));
    end
    if (ram_enb) rd_p1 <= mem[ram_addrb];
    ram_doutb <= rd_p1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected responses queued at grant time, due two cycles on.
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;

  task automatic expect_resp(logic id, logic [AW-1:0] a);
    exp_q.push_back({16'(cyc + 2), id, mem[a]});
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0 && exp_q[0][W-1 -: 16] == 16'(cyc)) begin
        e = exp_q.pop_front();
        chk("resp0_valid", rd0_resp_valid, !e[DW]);
        chk("resp1_valid", rd1_resp_valid, e[DW]);
        chk("resp_data", e[DW] ? rd1_resp_data : rd0_resp_data, e[DW-1:0]);
      end else begin
        chk("resp0_valid_idle", rd0_resp_valid, 1'b0);
        chk("resp1_valid_idle", rd1_resp_valid, 1'b0);
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic          r0v;
    logic [AW-1:0] r0a;
    logic          r1v;
    logic [AW-1:0] r1a;
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [SW-1:0] ws;
    logic          g0;
    logic          g1;
    logic [AW-1:0] ab;
    logic [15:0]   rdc;  // counters as seen during this row
    logic [15:0]   stc;
  } vec_t;

  function automatic vec_t mk(logic r0v, logic [AW-1:0] r0a, logic r1v,
                              logic [AW-1:0] r1a, logic wv, logic [AW-1:0] wa,
                              logic [DW-1:0] wd, logic [SW-1:0] ws, logic g0,
                              logic g1, logic [AW-1:0] ab, logic [15:0] rdc,
                              logic [15:0] stc);
    vec_t v;
    v.r0v = r0v; v.r0a = r0a; v.r1v = r1v; v.r1a = r1a;
    v.wv = wv; v.wa = wa; v.wd = wd; v.ws = ws;
    v.g0 = g0; v.g1 = g1; v.ab = ab; v.rdc = rdc; v.stc = stc;
    return v;
  endfunction

  task automatic apply(vec_t v);
    rd0_valid = v.r0v; rd0_addr = v.r0a;
    rd1_valid = v.r1v; rd1_addr = v.r1a;
    wr_valid = v.wv; wr_addr = v.wa; wr_data = v.wd; wr_strb = v.ws;
  endtask

  task automatic idle();
    rd0_valid = 0; rd0_addr = '0; rd1_valid = 0; rd1_addr = '0;
    wr_valid = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  vec_t vt[17];

  initial begin
    //            r0v r0a     r1v r1a     wv wa      wd        ws     g0 g1 ab      rdc stc
    vt[0]  = mk(1, 10'h005, 0, 10'h000, 0, 10'h000, 64'h0,    8'h00, 1, 0, 10'h005, 0,  0);
    vt[1]  = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 64'h0,    8'h00, 0, 0, 10'h000, 1,  0);
    vt[2]  = mk(0, 10'h000, 1, 10'h030, 0, 10'h000, 64'h0,    8'h00, 0, 1, 10'h030, 1,  0);
    vt[3]  = mk(1, 10'h040, 1, 10'h041, 0, 10'h000, 64'h0,    8'h00, 1, 0, 10'h040, 2,  0);
    vt[4]  = mk(1, 10'h040, 1, 10'h041, 0, 10'h000, 64'h0,    8'h00, 0, 1, 10'h041, 3,  0);
    vt[5]  = mk(1, 10'h040, 1, 10'h041, 0, 10'h000, 64'h0,    8'h00, 1, 0, 10'h040, 4,  0);
    vt[6]  = mk(1, 10'h040, 1, 10'h041, 0, 10'h000, 64'h0,    8'h00, 0, 1, 10'h041, 5,  0);
    vt[7]  = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 64'h0,    8'h00, 0, 0, 10'h000, 6,  0);
    vt[8]  = mk(1, 10'h010, 0, 10'h000, 1, 10'h010, 64'h1122, 8'hFF, 0, 0, 10'h000, 6,  0);
    vt[9]  = mk(1, 10'h010, 0, 10'h000, 0, 10'h000, 64'h0,    8'h00, 1, 0, 10'h010, 6,  1);
    vt[10] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 64'h0,    8'h00, 0, 0, 10'h000, 7,  1);
    vt[11] = mk(1, 10'h010, 0, 10'h000, 1, 10'h010, 64'h9999, 8'h00, 1, 0, 10'h010, 7,  1);
    vt[12] = mk(1, 10'h050, 1, 10'h051, 1, 10'h051, 64'hAB,   8'h01, 0, 0, 10'h000, 8,  1);
    vt[13] = mk(1, 10'h050, 1, 10'h051, 0, 10'h000, 64'h0,    8'h00, 0, 1, 10'h051, 8,  2);
    vt[14] = mk(1, 10'h060, 1, 10'h061, 1, 10'h061, 64'h77,   8'hFF, 1, 0, 10'h060, 9,  2);
    vt[15] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 64'h0,    8'h00, 0, 0, 10'h000, 10, 2);
    vt[16] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 64'h0,    8'h00, 0, 0, 10'h000, 10, 2);

    // ---- reset with every request asserted: nothing may leak out ----
    reset_n = 0;
    idle();
    rd0_valid = 1; rd1_valid = 1; wr_valid = 1; wr_strb = 8'hFF;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready0", rd0_ready, 1'b0);
    chk("rst_ready1", rd1_ready, 1'b0);
    chk("rst_enb", ram_enb, 1'b0);
    chk("rst_ena", ram_ena, 1'b0);
    chk("rst_resp", {rd0_resp_valid, rd1_resp_valid}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_counts", {rd_cnt, stall_cnt}, 32'h0);
    next_cycle();
    reset_n = 1;
    mon_en  = 1;

    // ---- table: arbitration, hazards, write path, counters ----
    for (int i = 0; i < 17; i++) begin
      apply(vt[i]);
      @(negedge clock);
      chk($sformatf("v%0d_ready0", i), rd0_ready, vt[i].g0);
      chk($sformatf("v%0d_ready1", i), rd1_ready, vt[i].g1);
      chk($sformatf("v%0d_enb", i), ram_enb, vt[i].g0 | vt[i].g1);
      if (vt[i].g0 | vt[i].g1) begin
        chk($sformatf("v%0d_addrb", i), ram_addrb, vt[i].ab);
        expect_resp(vt[i].g1, vt[i].ab);
      end
      chk($sformatf("v%0d_ena", i), ram_ena, vt[i].wv);
      if (vt[i].wv) begin
        chk($sformatf("v%0d_wea", i), ram_wea, vt[i].ws);
        chk($sformatf("v%0d_addra", i), ram_addra, vt[i].wa);
        chk($sformatf("v%0d_dina", i), ram_dina, vt[i].wd);
      end
      chk($sformatf("v%0d_rd_cnt", i), rd_cnt, vt[i].rdc);
      chk($sformatf("v%0d_stall_cnt", i), stall_cnt, vt[i].stc);
      next_cycle();
    end
    idle();
    chk("table_drained", exp_q.size(), 0);

    // ---- single read latency, busy window and data ----
    rd0_valid = 1; rd0_addr = 10'h005;
    @(negedge clock);
    chk("lat_ready0", rd0_ready, 1'b1);
    chk("lat_busy_t", busy, 1'b0);
    expect_resp(1'b0, 10'h005);
    next_cycle();
    idle();
    @(negedge clock);
    chk("lat_busy_t1", busy, 1'b1);
    chk("lat_rd_cnt", rd_cnt, 16'd11);
    next_cycle();
    @(negedge clock);
    chk("lat_busy_t2", busy, 1'b1);
    chk("lat_resp_valid", rd0_resp_valid, 1'b1);
    chk("lat_resp_data", rd0_resp_data, 64'hA5);
    next_cycle();
    @(negedge clock);
    chk("lat_busy_t3", busy, 1'b0);
    next_cycle();

    // ---- reset one cycle after a grant: read dropped, state cleared ----
    // Pointer now prefers client 1 (last grant went to client 0).
    rd0_valid = 1; rd0_addr = 10'h005;
    @(negedge clock);
    chk("mr_grant", rd0_ready, 1'b1);
    next_cycle();
    reset_n = 0;
    rd0_valid = 1; rd1_valid = 1; wr_valid = 1; wr_strb = 8'hFF; wr_addr = 10'h005;
    @(negedge clock);
    chk("mr_ready", {rd0_ready, rd1_ready}, 2'b00);
    chk("mr_enb", ram_enb, 1'b0);
    chk("mr_ena", ram_ena, 1'b0);
    chk("mr_busy", busy, 1'b0);
    next_cycle();
    reset_n = 1;
    idle();
    @(negedge clock);
    chk("mr_busy_after", busy, 1'b0);
    chk("mr_counts", {rd_cnt, stall_cnt}, 32'h0);
    next_cycle();
    rd0_valid = 1; rd0_addr = 10'h070; rd1_valid = 1; rd1_addr = 10'h071;
    @(negedge clock);
    chk("mr_contend_ready0", rd0_ready, 1'b1);
    chk("mr_contend_ready1", rd1_ready, 1'b0);
    expect_resp(1'b0, 10'h070);
    next_cycle();
    idle();
    repeat (3) next_cycle();
    chk("mr_drained", exp_q.size(), 0);

    // ---- 65536 grants wrap the read counter ----
    mon_en  = 0;
    reset_n = 0;
    repeat (2) next_cycle();
    reset_n = 1;
    rd0_valid = 1; rd0_addr = 10'h001;
    repeat (65535) next_cycle();
    @(negedge clock);
    chk("wrap_ffff", rd_cnt, 16'hFFFF);
    next_cycle();
    idle();
    @(negedge clock);
    chk("wrap_zero", rd_cnt, 16'h0000);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
- REQ-001 SHALL take parameter ADDR_W, default 10: RAM word-address width.
- REQ-002 SHALL take parameter DATA_W, default 64: RAM word width, a multiple of 8.
- REQ-003 SHALL take derived parameter STRB_W = DATA_W/8: byte-enable width, MSB strobe = most-significant byte.
- REQ-004 SHALL have port: clock  in  1  sole clock; RAM clka and clkb are tied to it.
- REQ-005 SHALL have port: reset_n  in  1  synchronous, active-low reset.
- REQ-006 SHALL have port: io_rd0_valid / io_rd0_ready / io_rd0_addr  in / out / in  1 / 1 / ADDR_W  client-0 read request.
- REQ-007 SHALL have port: io_rd0_resp_valid / io_rd0_resp_data  out / out  1 / DATA_W  client-0 read response.
- REQ-008 SHALL have port: io_rd1_* (the same five signals)  same directions and widths  client-1 read request and response.
- REQ-009 SHALL have port: io_wr_valid / io_wr_addr / io_wr_data / io_wr_strb  in  1 / ADDR_W / DATA_W / STRB_W  writer; always accepted.
- REQ-010 SHALL have port: io_ram_ena / io_ram_wea / io_ram_addra / io_ram_dina  out  1 / STRB_W / ADDR_W / DATA_W  to the RAM write port.
- REQ-011 SHALL have port: io_ram_enb / io_ram_addrb  out  1 / ADDR_W  to the RAM read port.
- REQ-012 SHALL have port: io_ram_doutb  in  DATA_W  RAM read data; 2-cycle registered latency.
- REQ-013 SHALL have port: io_busy  out  1  high while any read is in flight.
- REQ-014 SHALL have ports: io_stat_rd_cnt and io_stat_stall_cnt  out  16 each  granted-read count and hazard-stall count.

Function
- REQ-015 SHALL drive the write path combinationally: io_ram_ena = io_wr_valid; wea = strb; addra = wr_addr; dina = wr_data.
- REQ-016 SHALL arbitrate round-robin: one requester valid -> grant it; both valid -> grant the client not granted last; the pointer updates only on a grant.
- REQ-017 SHALL define a grant as the chosen client's rd_ready high while its rd_valid is high, with io_ram_enb = 1 and io_ram_addrb = that address in the same cycle.
- REQ-018 SHALL hold rd_ready low for the non-chosen client; at most one grant per cycle.
- REQ-019 SHALL treat a same-cycle hazard as: io_wr_valid = 1, wr_strb != 0, and wr_addr equal to the chosen read address.
- REQ-020 SHALL, on a hazard, issue no grant, leave the pointer unchanged and increment io_stat_stall_cnt; the read is granted the next cycle and returns post-write data.
- REQ-021 SHALL carry a valid+client-ID tag through a 2-stage pipeline; a grant in cycle t pulses rd<id>_resp_valid for exactly one cycle in t+2.
- REQ-022 SHALL drive both resp_data outputs from io_ram_doutb directly; resp_data is meaningful only while that client's resp_valid is high.
- REQ-023 SHALL sustain back-to-back grants at one per cycle, with responses in grant order; responses have no backpressure.
- REQ-024 SHALL set io_busy = OR of the two pipeline-stage valids.
- REQ-025 SHALL make both statistics counters wrap modulo 2^16; io_stat_rd_cnt increments once per grant.

Reset
- REQ-026 SHALL, while reset_n = 0 at a clock edge, clear pipeline valids, counters and pointer (next preference = client 0).
- REQ-027 SHALL hold io_ram_ena, io_ram_enb, all rd_ready, all resp_valid and io_busy at 0 throughout reset, regardless of request inputs.
- REQ-028 SHALL, on reset mid-operation, drop in-flight reads with no resp_valid and issue no writes during reset.

Structure
- REQ-029 SHALL take RAM geometry constants (ADDR_W, DATA_W, STRB_W) from the shared RAM-geometry package, alongside the client-ID enum {CLI0, CLI1}.
- REQ-030 SHALL place the round-robin pointer plus grant logic in one sub-module, rr_arb2; the tag pipeline, hazard check and counters stay in the top.

Verification
- REQ-031 SHALL cover: rd0 alone at addr 0x005 holding 0xA5 -> rd0_ready = 1 in t, rd0_resp_valid in t+2 with data 0xA5, rd_cnt = 1.
- REQ-032 SHALL cover: rd0 and rd1 both held valid for 4 cycles -> grants 0,1,0,1; responses tagged 0,1,0,1 in cycles t+2..t+5.
- REQ-033 SHALL cover: write 0x1122 to 0x010 (strb all 1s) with rd0 at 0x010 in the same cycle -> stall_cnt = 1, grant in t+1, resp in t+3 = 0x1122.
- REQ-034 SHALL cover: write to 0x010 with strb = 0 plus rd0 at 0x010 -> no stall, grant in t, old data returned.
- REQ-035 SHALL cover: reset_n low one cycle after a grant -> no resp_valid, busy = 0, counters 0, next contention grants client 0.
- REQ-036 SHALL cover: 65536 grants -> io_stat_rd_cnt wraps to 0.
